// File: rtl/peripheral_axi4_pkg.sv
// AXI4 protocol constants shared by the peripheral bus-functional models.
package peripheral_axi4_pkg;

    localparam logic [1:0] AXI_RESPONSE_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESPONSE_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESPONSE_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESPONSE_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    // Response encodings grow with severity, so the worst one is the largest.
    function automatic logic [1:0] axi_worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/peripheral_bfm_master_generic_axi4.sv
// Generic AXI4 master BFM: turns one command into one AW/W/B or AR/R burst
// and reports completion with a single done pulse and the worst response seen.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WR_ADDR | presenting AW until awready
// WR_DATA | streaming wd_* onto W until the last beat
// WR_RESP | waiting for the B response
// RD_ADDR | presenting AR until arready
// RD_DATA | collecting R beats onto rd_*
// DONE    | one-cycle completion pulse
module peripheral_bfm_master_generic_axi4
    import peripheral_axi4_pkg::*;
#(
    parameter logic [3:0] AXI_ID  = 4'h0,
    parameter int         TIMEOUT = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [3:0]  cmd_strb,

    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,

    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_last,

    output logic        done,
    output logic [1:0]  done_resp,

    output logic [3:0]  awid,
    output logic [31:0] awadr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wrdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [3:0]  strb_q;
    logic [3:0]  beat_cnt;
    logic [1:0]  resp_q;
    logic [31:0] to_cnt;
    logic        rd_valid_q;
    logic        rd_last_q;
    logic [31:0] rd_data_q;

    logic cmd_hs;
    logic w_beat;
    logic r_beat;
    logic last_cnt;
    logic waiting;
    logic progress;
    logic to_hit;
    logic r_frame_err;

    assign cmd_hs      = cmd_valid && (state == IDLE);
    assign w_beat      = (state == WR_DATA) && wd_valid && wready;
    assign r_beat      = (state == RD_DATA) && rvalid;
    assign last_cnt    = (beat_cnt == len_q);
    assign r_frame_err = rlast != last_cnt;
    assign waiting     = (state == WR_ADDR) || (state == WR_DATA) || (state == WR_RESP) ||
                         (state == RD_ADDR) || (state == RD_DATA);

    always_comb begin
        progress = 1'b0;
        case (state)
            WR_ADDR: progress = awready;
            WR_DATA: progress = w_beat;
            WR_RESP: progress = bvalid;
            RD_ADDR: progress = arready;
            RD_DATA: progress = rvalid;
            default: progress = 1'b0;
        endcase
    end

    // Timeout fires only on a cycle with no handshake, so a valid is held for exactly TIMEOUT cycles.
    assign to_hit = (TIMEOUT != 0) && waiting && !progress && (to_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_write ? WR_ADDR : RD_ADDR;
            WR_ADDR: if (awready) state_nxt = WR_DATA;
            WR_DATA: if (w_beat && last_cnt) state_nxt = WR_RESP;
            WR_RESP: if (bvalid) state_nxt = DONE;
            RD_ADDR: if (arready) state_nxt = RD_DATA;
            RD_DATA: if (rvalid && (last_cnt || rlast)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (to_hit) begin
            state_nxt = DONE;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            addr_q     <= '0;
            len_q      <= '0;
            strb_q     <= '0;
            beat_cnt   <= '0;
            resp_q     <= AXI_RESPONSE_OKAY;
            to_cnt     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= r_beat;
            rd_last_q  <= r_beat && last_cnt;
            if (r_beat) begin
                rd_data_q <= rdata;
            end

            if ((state != state_nxt) || w_beat || r_beat) begin
                to_cnt <= '0;
            end else if (waiting && (TIMEOUT != 0)) begin
                to_cnt <= to_cnt + 32'd1;
            end

            if (cmd_hs) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                strb_q <= cmd_strb;
                resp_q <= AXI_RESPONSE_OKAY;
            end

            // Data states are only entered from the address states.
            if ((state == WR_ADDR) || (state == RD_ADDR)) begin
                beat_cnt <= '0;
            end else if (w_beat || r_beat) begin
                beat_cnt <= beat_cnt + 4'd1;
            end

            if ((state == WR_RESP) && bvalid) begin
                resp_q <= bresp;
            end
            if (r_beat) begin
                resp_q <= r_frame_err ? AXI_RESPONSE_SLVERR : axi_worst_resp(resp_q, rresp);
            end
            if (to_hit) begin
                resp_q <= AXI_RESPONSE_SLVERR;
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign wd_ready  = (state == WR_DATA) && wready;

    assign awid    = AXI_ID;
    assign awadr   = addr_q;
    assign awlen   = len_q;
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'b000;
    assign awvalid = (state == WR_ADDR);

    assign wid    = AXI_ID;
    assign wrdata = (state == WR_DATA) ? wd_data : 32'h0;
    assign wstrb  = strb_q;
    assign wlast  = (state == WR_DATA) && last_cnt;
    assign wvalid = (state == WR_DATA) && wd_valid;

    assign bready = (state == WR_RESP);

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = AXI_SIZE_4B;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'b000;
    assign arvalid = (state == RD_ADDR);

    assign rready = (state == RD_DATA);

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;
    assign done      = (state == DONE);
    assign done_resp = resp_q;

endmodule

// File: tb/tb_peripheral_bfm_master_generic_axi4.sv
// Scoreboard bench for the AXI4 master BFM: directed commands push expectations,
// a negedge monitor pops and compares every AW/W/AR handshake, rd beat and done pulse.
module tb_peripheral_bfm_master_generic_axi4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0, cmd_strb = '0;
    logic        wd_valid = 1'b0, wd_ready;
    logic [31:0] wd_data = '0;
    logic        rd_valid, rd_last, done;
    logic [31:0] rd_data;
    logic [1:0]  done_resp;
    logic [3:0]  awid, awlen, awcache, wid, wstrb, arid, arlen, arcache;
    logic [31:0] awadr, wrdata, araddr;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, awlock, arlock;
    logic        awvalid, wlast, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
    logic        rvalid = 1'b0, rlast = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;
    logic [3:0]  bid = 4'h5, rid = 4'h5;

    always #5 aclk = ~aclk;

    peripheral_bfm_master_generic_axi4 #(.AXI_ID(4'h5), .TIMEOUT(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_strb(cmd_strb),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name);
        total++;
        bad++;
        $display("FAIL %s_unexpected: got=event exp=none", name);
    endtask

    // Expectation queues: aw/ar {len,addr}, w {last,strb,data}, rd {last,data}.
    logic [35:0] exp_aw[$];
    logic [35:0] exp_ar[$];
    logic [36:0] exp_w[$];
    logic [32:0] exp_rd[$];
    logic [1:0]  exp_done[$];
    // Stimulus queues: wd stream data, slave R beats {resp,last,data}.
    logic [31:0] wd_q[$];
    logic [34:0] r_q[$];

    logic [35:0] e_aw, e_ar;
    logic [36:0] e_w;
    logic [32:0] e_rd;
    logic [1:0]  e_done;
    logic [34:0] e_r;

    always @(negedge aclk) begin
        if (awvalid && awready) begin
            if (exp_aw.size() == 0) unexp("aw");
            else begin
                e_aw = exp_aw.pop_front();
                chk("awadr", awadr, e_aw[31:0]);
                chk("awlen", 32'(awlen), 32'(e_aw[35:32]));
                chk("awsize", 32'(awsize), 32'h2);
                chk("awburst", 32'(awburst), 32'h1);
                chk("awid", 32'(awid), 32'h5);
            end
        end
        if (wvalid && wready) begin
            if (exp_w.size() == 0) unexp("w");
            else begin
                e_w = exp_w.pop_front();
                chk("wrdata", wrdata, e_w[31:0]);
                chk("wstrb", 32'(wstrb), 32'(e_w[35:32]));
                chk("wlast", 32'(wlast), 32'(e_w[36]));
            end
        end
        if (arvalid && arready) begin
            if (exp_ar.size() == 0) unexp("ar");
            else begin
                e_ar = exp_ar.pop_front();
                chk("araddr", araddr, e_ar[31:0]);
                chk("arlen", 32'(arlen), 32'(e_ar[35:32]));
            end
        end
        if (rd_valid) begin
            if (exp_rd.size() == 0) unexp("rd");
            else begin
                e_rd = exp_rd.pop_front();
                chk("rd_data", rd_data, e_rd[31:0]);
                chk("rd_last", 32'(rd_last), 32'(e_rd[32]));
            end
        end
        if (done) begin
            if (exp_done.size() == 0) unexp("done");
            else begin
                e_done = exp_done.pop_front();
                chk("done_resp", 32'(done_resp), 32'(e_done));
            end
        end
    end

    // Slave model: handshakes sampled mid-cycle, responses driven just after the edge.
    logic hs_wl = 1'b0, hs_b = 1'b0, hs_ar = 1'b0, hs_wd = 1'b0;
    logic aw_en = 1'b1, w_en = 1'b1, w_toggle = 1'b0, r_active = 1'b0;
    logic [1:0] b_resp_val = 2'b00;
    int aw_hi_cnt = 0;

    always @(negedge aclk) begin
        hs_wl = wvalid && wready && wlast;
        hs_b  = bvalid && bready;
        hs_ar = arvalid && arready;
        hs_wd = wd_valid && wd_ready;
        if (awvalid === 1'b1) aw_hi_cnt++;
    end

    always @(posedge aclk) begin
        #1;
        if (!aresetn) begin
            awready = 1'b0; arready = 1'b0; wready = 1'b0;
            bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0; r_active = 1'b0;
        end else begin
            awready = aw_en;
            arready = 1'b1;
            wready  = !w_en ? 1'b0 : (w_toggle ? !wready : 1'b1);
            if (hs_b) bvalid = 1'b0;
            if (hs_wl) begin
                bvalid = 1'b1;
                bresp  = b_resp_val;
            end
            if (hs_ar) r_active = 1'b1;
            if (r_active && r_q.size() > 0) begin
                e_r    = r_q.pop_front();
                rvalid = 1'b1;
                rdata  = e_r[31:0];
                rlast  = e_r[32];
                rresp  = e_r[34:33];
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                r_active = 1'b0;
            end
        end
        if (hs_wd && wd_q.size() > 0) void'(wd_q.pop_front());
        wd_valid = wd_q.size() > 0;
        wd_data  = (wd_q.size() > 0) ? wd_q[0] : 32'h0;
    end

    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [3:0] l, input logic [3:0] s);
        int n = 0;
        @(negedge aclk);
        while (!cmd_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_strb = s;
        @(posedge aclk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [1:0] er);
        int n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!done && n < 300);
        chk("done_seen", 32'(done), 32'h1);
        @(negedge aclk);
        chk("done_one_cycle", 32'(done), 32'h0);
        repeat (3) @(negedge aclk);
        chk("done_resp_hold", 32'(done_resp), 32'(er));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_awvalid", 32'(awvalid), 32'h0);
        chk("rst_wvalid", 32'(wvalid), 32'h0);
        chk("rst_arvalid", 32'(arvalid), 32'h0);
        chk("rst_bready", 32'(bready), 32'h0);
        chk("rst_rready", 32'(rready), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_done_resp", 32'(done_resp), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_awadr", awadr, 32'h0);
        chk("rst_awlen", 32'(awlen), 32'h0);
        aresetn = 1'b1;

        // single write
        wd_q.push_back(32'hDEADBEEF);
        exp_aw.push_back({4'd0, 32'h10});
        exp_w.push_back({1'b1, 4'hF, 32'hDEADBEEF});
        exp_done.push_back(2'b00);
        do_cmd(1'b1, 32'h10, 4'd0, 4'hF);
        wait_done(2'b00);

        // 4-beat write burst with wready toggling
        w_toggle = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wd_q.push_back(32'h1111_0000 + 32'(i));
            exp_w.push_back({(i == 4), 4'h3, 32'h1111_0000 + 32'(i)});
        end
        exp_aw.push_back({4'd3, 32'h40});
        exp_done.push_back(2'b00);
        do_cmd(1'b1, 32'h40, 4'd3, 4'h3);
        wait_done(2'b00);
        w_toggle = 1'b0;
        chk("w_burst_all_beats", 32'(exp_w.size()), 32'h0);

        // write answered with SLVERR
        b_resp_val = 2'b10;
        wd_q.push_back(32'h0123_4567);
        exp_aw.push_back({4'd0, 32'h14});
        exp_w.push_back({1'b1, 4'h1, 32'h0123_4567});
        exp_done.push_back(2'b10);
        do_cmd(1'b1, 32'h14, 4'd0, 4'h1);
        wait_done(2'b10);
        b_resp_val = 2'b00;

        // 2-beat read
        r_q.push_back({2'b00, 1'b0, 32'h11});
        r_q.push_back({2'b00, 1'b1, 32'h22});
        exp_ar.push_back({4'd1, 32'h20});
        exp_rd.push_back({1'b0, 32'h11});
        exp_rd.push_back({1'b1, 32'h22});
        exp_done.push_back(2'b00);
        do_cmd(1'b0, 32'h20, 4'd1, 4'hF);
        wait_done(2'b00);

        // 3-beat read, worst response EXOKAY
        r_q.push_back({2'b00, 1'b0, 32'hA0});
        r_q.push_back({2'b01, 1'b0, 32'hA1});
        r_q.push_back({2'b00, 1'b1, 32'hA2});
        exp_ar.push_back({4'd2, 32'h24});
        exp_rd.push_back({1'b0, 32'hA0});
        exp_rd.push_back({1'b0, 32'hA1});
        exp_rd.push_back({1'b1, 32'hA2});
        exp_done.push_back(2'b01);
        do_cmd(1'b0, 32'h24, 4'd2, 4'hF);
        wait_done(2'b01);

        // early rlast
        r_q.push_back({2'b00, 1'b1, 32'h55});
        exp_ar.push_back({4'd1, 32'h30});
        exp_rd.push_back({1'b0, 32'h55});
        exp_done.push_back(2'b10);
        do_cmd(1'b0, 32'h30, 4'd1, 4'hF);
        wait_done(2'b10);

        // final beat without rlast
        r_q.push_back({2'b00, 1'b0, 32'hB0});
        exp_ar.push_back({4'd0, 32'h28});
        exp_rd.push_back({1'b1, 32'hB0});
        exp_done.push_back(2'b10);
        do_cmd(1'b0, 32'h28, 4'd0, 4'hF);
        wait_done(2'b10);

        // AW timeout
        aw_en = 1'b0;
        aw_hi_cnt = 0;
        exp_done.push_back(2'b10);
        do_cmd(1'b1, 32'h80, 4'd0, 4'hF);
        wait_done(2'b10);
        chk("aw_timeout_cycles", 32'(aw_hi_cnt), 32'd16);
        chk("aw_timeout_dropped", 32'(awvalid), 32'h0);
        aw_en = 1'b1;

        // reset while in WR_DATA
        w_en = 1'b0;
        for (int i = 0; i < 4; i++) wd_q.push_back(32'hC0 + 32'(i));
        exp_aw.push_back({4'd3, 32'h90});
        do_cmd(1'b1, 32'h90, 4'd3, 4'hF);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!wvalid && n < 50);
        chk("wvalid_before_reset", 32'(wvalid), 32'h1);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("midrst_awvalid", 32'(awvalid), 32'h0);
        chk("midrst_wvalid", 32'(wvalid), 32'h0);
        chk("midrst_wd_ready", 32'(wd_ready), 32'h0);
        chk("midrst_arvalid", 32'(arvalid), 32'h0);
        chk("midrst_bready", 32'(bready), 32'h0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_done_resp", 32'(done_resp), 32'h0);
        chk("midrst_awadr", awadr, 32'h0);
        wd_q.delete();
        aresetn = 1'b1;
        w_en = 1'b1;
        repeat (6) @(negedge aclk);

        // single-beat read with DECERR after recovery
        r_q.push_back({2'b11, 1'b1, 32'h77});
        exp_ar.push_back({4'd0, 32'h60});
        exp_rd.push_back({1'b1, 32'h77});
        exp_done.push_back(2'b11);
        do_cmd(1'b0, 32'h60, 4'd0, 4'hF);
        wait_done(2'b11);

        chk("left_aw", 32'(exp_aw.size()), 32'h0);
        chk("left_w", 32'(exp_w.size()), 32'h0);
        chk("left_ar", 32'(exp_ar.size()), 32'h0);
        chk("left_rd", 32'(exp_rd.size()), 32'h0);
        chk("left_done", 32'(exp_done.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peripheral_bfm_master_generic_axi4.md
PERIPHERAL_BFM_MASTER_GENERIC_AXI4 -- requirements
Module: peripheral_bfm_master_generic_axi4

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0: value driven on awid/arid.
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum cycles spent waiting on any single handshake; 0 disables the timeout.
REQ-003 SHALL use reset aresetn, synchronous, active-low; clock aclk.
REQ-004 aclk  in  1  clock; aresetn  in  1  synchronous active-low reset.
REQ-005 cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in 32, cmd_len in 4 (beats-1), cmd_strb in 4: command port.
REQ-006 wd_valid in 1, wd_ready out 1, wd_data in 32: write-data stream.
REQ-007 rd_valid out 1, rd_data out 32, rd_last out 1: read-data stream, no backpressure.
REQ-008 done out 1 (one-cycle pulse), done_resp out 2: completion and response.
REQ-009 AW: awid 4, awadr 32, awlen 4, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid out; awready in.
REQ-010 W: wid 4, wrdata 32, wstrb 4, wlast 1, wvalid out; wready in.
REQ-011 B: bid 4, bresp 2, bvalid in; bready out.
REQ-012 AR: arid 4, araddr 32, arlen 4, arsize 3, arlock 2, arcache 4, arprot 3, arvalid out; arready in.
REQ-013 R: rid 4, rdata 32, rresp 2, rlast 1, rvalid in; rready out.

Function
REQ-014 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; cmd_valid&cmd_ready latches cmd_* and moves to WR_ADDR (cmd_write=1) or RD_ADDR.
REQ-016 Fixed fields: awsize/arsize=3'b010, awburst=INCR, lock/cache/prot=0, wid=AXI_ID.
REQ-017 WR_ADDR/RD_ADDR: awvalid/arvalid=1 with addr/len stable from the cycle after acceptance until the cycle awready/arready is sampled 1; then WR_DATA/RD_DATA.
REQ-018 WR_DATA: wvalid=wd_valid, wrdata=wd_data, wstrb=latched strb, wd_ready=wready (combinational); a beat transfers on wvalid&wready.
REQ-019 A 4-bit beat counter SHALL reset to 0 on entry to WR_DATA/RD_DATA and increment per beat; wlast=1 when counter==len; the last beat moves to WR_RESP.
REQ-020 WR_RESP: bready=1; on bvalid, capture bresp, go to DONE.
REQ-021 RD_DATA: rready=1; each rvalid beat SHALL appear on rd_valid/rd_data registered one cycle later; rd_last=1 on beat counter==len; done_resp = worst (numerically largest) rresp across the burst.
REQ-022 An rlast arriving before counter==len, or counter==len without rlast, SHALL end the burst with done_resp=SLVERR.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; done_resp held until next command.
REQ-024 Timeout counter resets on every state change; reaching TIMEOUT (when nonzero) in any waiting state SHALL drop all valids and go to DONE with done_resp=SLVERR.
REQ-025 awvalid/arvalid/wvalid SHALL never deassert before their handshake except by timeout.

Reset
REQ-026 On aresetn=0 at a clock edge: state IDLE, all valid/ready outputs 0 except cmd_ready=1, addr/data/len outputs 0, done=0, done_resp=OKAY, counters 0.
REQ-027 Reset mid-transaction SHALL abort immediately with no done pulse.

Structure
REQ-028 AXI_RESPONSE_* and burst-type constants SHALL come from peripheral_axi4_pkg; the state typedef stays local to the module.
REQ-029 No sub-module is required; a single module is the natural structure.

Verification
REQ-030 Single write 0x10, data 0xDEADBEEF, strb 4'hF, slave bvalid OKAY -> one AW/W beat, wlast=1, done with resp 2'b00.
REQ-031 Write burst len=3 at 0x40 with wready toggling every other cycle -> exactly 4 beats, wlast only on 4th, wrdata sequence preserved.
REQ-032 Read len=1 at 0x20, slave returns 0x11,0x22 with rlast on 2nd -> rd_data 0x11,0x22, rd_last on 2nd, done resp OKAY.
REQ-033 Read len=1, slave asserts rlast on first beat -> done_resp=SLVERR.
REQ-034 TIMEOUT=16, awready held 0 -> awvalid drops after 16 cycles, done with SLVERR.
REQ-035 aresetn=0 during WR_DATA -> next cycle all valids 0, cmd_ready=1, no done.
